// File: rtl/mmio_pkg.sv
// Shared constants for the dmem-side MMIO responder:
// register offsets and STATUS bit positions.
package mmio_pkg;

   localparam logic [3:0] OFF_TXDATA  = 4'h0;
   localparam logic [3:0] OFF_STATUS  = 4'h1;
   localparam logic [3:0] OFF_CYCLE   = 4'h2;
   localparam logic [3:0] OFF_SCRATCH = 4'h3;
   localparam logic [3:0] OFF_IRQ_EN  = 4'h4;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_OVF   = 2;
   localparam int ST_CNT   = 4;
   localparam int ST_CNT_W = 5;

endpackage

// File: rtl/mmio_responder_sync_fifo.sv
// Small synchronous FIFO; head is read straight from storage.
// A push into a full FIFO is taken only if a pop frees a slot that cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder beside dmem: decodes the top 16 words, gates RAM
// writes there, and returns register reads with syncram latency.
module mmio_responder
   import mmio_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int FIFO_DEPTH = 8,
   parameter logic [ADDR_W-1:0] MMIO_BASE = 12'hFF0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address_dmem,
   input  logic [DATA_W-1:0] data,
   input  logic              wren,
   output logic              dmem_wren,
   output logic              mmio_sel,
   output logic [DATA_W-1:0] q_mmio,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              irq
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic             hit;
   logic [3:0]       off;
   logic             wr_hit;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic [DATA_W-1:0] cycle;
   logic [DATA_W-1:0] scratch;
   logic [1:0]        irq_en;
   logic [DATA_W-1:0] status;
   logic [DATA_W-1:0] rdata;

   assign off       = address_dmem[3:0];
   assign hit       = (address_dmem[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
   assign dmem_wren = wren & ~hit;
   assign wr_hit    = wren & hit;
   assign push      = wr_hit & (off == OFF_TXDATA);
   assign pop       = tx_valid & tx_ready;
   assign tx_valid  = ~empty;

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock(clock),
      .reset(reset),
      .push (push),
      .din  (data[7:0]),
      .pop  (pop),
      .dout (tx_data),
      .full (full),
      .empty(empty),
      .count(count)
   );

   always_comb begin
      status = '0;
      status[ST_FULL]  = full;
      status[ST_EMPTY] = empty;
      status[ST_OVF]   = overflow;
      status[ST_CNT +: ST_CNT_W] = ST_CNT_W'(count);
   end

   // Pre-edge state only, so same-cycle writes read back the old value.
   always_comb begin
      rdata = '0;
      if (hit) begin
         case (off)
            OFF_STATUS:  rdata = status;
            OFF_CYCLE:   rdata = cycle;
            OFF_SCRATCH: rdata = scratch;
            OFF_IRQ_EN:  rdata = DATA_W'(irq_en);
            default:     rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         mmio_sel <= 1'b0;
         q_mmio   <= '0;
         overflow <= 1'b0;
         cycle    <= '0;
         scratch  <= '0;
         irq_en   <= '0;
         irq      <= 1'b0;
      end else begin
         mmio_sel <= hit;
         q_mmio   <= rdata;
         if (wr_hit && off == OFF_CYCLE) cycle <= data;
         else cycle <= cycle + DATA_W'(1);
         if (wr_hit && off == OFF_SCRATCH) scratch <= data;
         if (wr_hit && off == OFF_IRQ_EN) irq_en <= data[1:0];
         // A fresh drop wins over a coincident STATUS read clear.
         if (push && full && !pop) overflow <= 1'b1;
         else if (hit && off == OFF_STATUS) overflow <= 1'b0;
         irq <= (irq_en[0] & empty) | (irq_en[1] & overflow);
      end
   end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: register map, FIFO, irq, reset.
module tb_mmio_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic        dmem_wren;
   logic        mmio_sel;
   logic [31:0] q_mmio;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        irq;

   int nvec = 0;
   int nerr = 0;

   mmio_responder dut (
      .clock(clock),
      .reset(reset),
      .address_dmem(address_dmem),
      .data(data),
      .wren(wren),
      .dmem_wren(dmem_wren),
      .mmio_sel(mmio_sel),
      .q_mmio(q_mmio),
      .tx_valid(tx_valid),
      .tx_data(tx_data),
      .tx_ready(tx_ready),
      .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      address_dmem = a;
      data = d;
      wren = 1'b1;
      cyc();
      wren = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] q,
                     output logic s);
      address_dmem = a;
      wren = 1'b0;
      cyc();
      q = q_mmio;
      s = mmio_sel;
   endtask

   task automatic test_reset();
      logic [31:0] q;
      logic s;
      reset = 1'b0;
      cyc();
      cyc();
      nvec++;
      if ({mmio_sel, q_mmio, tx_valid, tx_data, irq} !== 42'd0) begin
         nerr++;
         $display("FAIL reset_outs got sel=%b q=%h v=%b d=%h irq=%b want 0",
                  mmio_sel, q_mmio, tx_valid, tx_data, irq);
      end
      reset = 1'b1;
      rd(12'hFF1, q, s);
      nvec++;
      if (q !== 32'h002 || s !== 1'b1) begin
         nerr++;
         $display("FAIL reset_status got %h sel=%b want 00000002 sel=1", q, s);
      end
      rd(12'hFF3, q, s);
      nvec++;
      if (q !== 32'h0 || s !== 1'b1) begin
         nerr++;
         $display("FAIL reset_scratch got %h sel=%b want 0 sel=1", q, s);
      end
      rd(12'h010, q, s);
      nvec++;
      if (q !== 32'h0 || s !== 1'b0) begin
         nerr++;
         $display("FAIL non_mmio_read got %h sel=%b want 0 sel=0", q, s);
      end
   endtask

   task automatic test_regs();
      logic [31:0] q;
      logic s;
      address_dmem = 12'hFF3;
      data = 32'hA5A5A5A5;
      wren = 1'b1;
      #1;
      nvec++;
      if (dmem_wren !== 1'b0) begin
         nerr++;
         $display("FAIL gate_mmio dmem_wren got %b want 0", dmem_wren);
      end
      cyc();
      wren = 1'b0;
      rd(12'hFF3, q, s);
      nvec++;
      if (q !== 32'hA5A5A5A5) begin
         nerr++;
         $display("FAIL scratch_rw got %h want a5a5a5a5", q);
      end
      address_dmem = 12'h100;
      wren = 1'b1;
      #1;
      nvec++;
      if (dmem_wren !== 1'b1) begin
         nerr++;
         $display("FAIL pass_ram dmem_wren got %b want 1", dmem_wren);
      end
      wren = 1'b0;
      wr(12'hFF4, 32'hFFFFFFFF);
      rd(12'hFF4, q, s);
      nvec++;
      if (q !== 32'h3) begin
         nerr++;
         $display("FAIL irq_en_mask got %h want 00000003", q);
      end
      wr(12'hFF4, 32'h0);
      wr(12'hFFF, 32'h1234);
      rd(12'hFFF, q, s);
      nvec++;
      if (q !== 32'h0 || s !== 1'b1) begin
         nerr++;
         $display("FAIL unmapped got %h sel=%b want 0 sel=1", q, s);
      end
      rd(12'hFF0, q, s);
      nvec++;
      if (q !== 32'h0) begin
         nerr++;
         $display("FAIL txdata_read got %h want 0", q);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] q;
      logic s;
      tx_ready = 1'b0;
      for (int i = 1; i <= 9; i++) wr(12'hFF0, 32'(i));
      rd(12'hFF1, q, s);
      nvec++;
      if (q !== 32'h085) begin
         nerr++;
         $display("FAIL ovf_status got %h want 00000085", q);
      end
      rd(12'hFF1, q, s);
      nvec++;
      if (q !== 32'h081) begin
         nerr++;
         $display("FAIL ovf_cleared got %h want 00000081", q);
      end
      address_dmem = 12'h000;
      tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         nvec++;
         if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
            nerr++;
            $display("FAIL drain%0d got v=%b d=%h want v=1 d=%h",
                     i, tx_valid, tx_data, 8'(i));
         end
         cyc();
      end
      nvec++;
      if (tx_valid !== 1'b0) begin
         nerr++;
         $display("FAIL drained_valid got %b want 0", tx_valid);
      end
      tx_ready = 1'b0;
      rd(12'hFF1, q, s);
      nvec++;
      if (q !== 32'h002) begin
         nerr++;
         $display("FAIL drained_status got %h want 00000002", q);
      end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] q;
      logic s;
      logic [7:0] exp;
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) wr(12'hFF0, 32'h10 + 32'(i));
      address_dmem = 12'hFF0;
      data = 32'h3C;
      wren = 1'b1;
      tx_ready = 1'b1;
      cyc();
      wren = 1'b0;
      tx_ready = 1'b0;
      rd(12'hFF1, q, s);
      nvec++;
      if (q !== 32'h081) begin
         nerr++;
         $display("FAIL fullpp_status got %h want 00000081", q);
      end
      tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         exp = (i == 8) ? 8'h3C : 8'h10 + 8'(i);
         nvec++;
         if (tx_valid !== 1'b1 || tx_data !== exp) begin
            nerr++;
            $display("FAIL fullpp%0d got v=%b d=%h want v=1 d=%h",
                     i, tx_valid, tx_data, exp);
         end
         cyc();
      end
      tx_ready = 1'b0;
      nvec++;
      if (tx_valid !== 1'b0) begin
         nerr++;
         $display("FAIL fullpp_empty got %b want 0", tx_valid);
      end
   endtask

   task automatic test_irq();
      wr(12'hFF4, 32'h1);
      nvec++;
      if (irq !== 1'b0) begin
         nerr++;
         $display("FAIL irq_latency got %b want 0", irq);
      end
      cyc();
      nvec++;
      if (irq !== 1'b1) begin
         nerr++;
         $display("FAIL irq_empty got %b want 1", irq);
      end
      tx_ready = 1'b0;
      wr(12'hFF0, 32'h55);
      cyc();
      nvec++;
      if (irq !== 1'b0) begin
         nerr++;
         $display("FAIL irq_nonempty got %b want 0", irq);
      end
      nvec++;
      if (tx_data !== 8'h55) begin
         nerr++;
         $display("FAIL irq_head got %h want 55", tx_data);
      end
      tx_ready = 1'b1;
      cyc();
      tx_ready = 1'b0;
      cyc();
      nvec++;
      if (irq !== 1'b1) begin
         nerr++;
         $display("FAIL irq_reempty got %b want 1", irq);
      end
      wr(12'hFF4, 32'h0);
      cyc();
   endtask

   task automatic test_cycle();
      logic [31:0] q;
      logic s;
      wr(12'hFF2, 32'hFFFFFFFE);
      rd(12'hFF2, q, s);
      nvec++;
      if (q !== 32'hFFFFFFFE) begin
         nerr++;
         $display("FAIL cycle_load got %h want fffffffe", q);
      end
      rd(12'hFF2, q, s);
      nvec++;
      if (q !== 32'hFFFFFFFF) begin
         nerr++;
         $display("FAIL cycle_inc got %h want ffffffff", q);
      end
      rd(12'hFF2, q, s);
      nvec++;
      if (q !== 32'h0) begin
         nerr++;
         $display("FAIL cycle_wrap got %h want 00000000", q);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] q;
      logic s;
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) wr(12'hFF0, 32'hE0 + 32'(i));
      nvec++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hE0) begin
         nerr++;
         $display("FAIL mid_queued got v=%b d=%h want v=1 d=e0",
                  tx_valid, tx_data);
      end
      reset = 1'b0;
      cyc();
      nvec++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin
         nerr++;
         $display("FAIL mid_reset got v=%b d=%h want v=0 d=00",
                  tx_valid, tx_data);
      end
      reset = 1'b1;
      rd(12'hFF1, q, s);
      nvec++;
      if (q !== 32'h002) begin
         nerr++;
         $display("FAIL mid_status got %h want 00000002", q);
      end
      rd(12'hFF2, q, s);
      nvec++;
      if (q !== 32'h1) begin
         nerr++;
         $display("FAIL mid_cycle got %h want 00000001", q);
      end
   endtask

   initial begin
      reset = 1'b0;
      address_dmem = 12'h0;
      data = 32'h0;
      wren = 1'b0;
      tx_ready = 1'b0;
      test_reset();
      test_regs();
      test_overflow();
      test_full_push_pop();
      test_irq();
      test_cycle();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
